bus_xfer_fifo: RTL
==================

BUS_XFER_FIFO -- requirements
Module: bus_xfer_fifo

Interface
REQ-001 SHALL import IfcPkg::* in the module header, between the module name and the parameter/port lists.
REQ-002 WIDTH, default IfcPkg::WIDTH (8), data bits per entry; SHALL be >= 1.
REQ-003 DEPTH, default 4, entry count; SHALL be a power of two >= 2.
REQ-004 AFULL_LVL, default DEPTH-1, occupancy at or above which afull asserts; SHALL be in 1..DEPTH.
REQ-005 clk  input  1  single clock; all state updates on rising edge.
REQ-006 rst  input  1  reset, synchronous, active-high.
REQ-007 in_valid  input  1  producer offers in_data.
REQ-008 in_data  input  WIDTH  producer payload.
REQ-009 in_ready  output  1  space available (occupancy < DEPTH).
REQ-010 out_valid  output  1  entry available (occupancy > 0).
REQ-011 out_data  output  WIDTH  oldest entry; value SHALL be stable while out_valid=1 and out_ready=0.
REQ-012 out_ready  input  1  consumer accepts out_data.
REQ-013 count  output  $clog2(DEPTH)+1  current occupancy, 0..DEPTH.
REQ-014 afull  output  1  count >= AFULL_LVL.
REQ-015 ovf  output  1  sticky: push attempted while full.
REQ-016 udf  output  1  sticky: pop attempted while empty.
REQ-017 clr_err  input  1  clears ovf and udf.

Function
REQ-018 Push SHALL occur on a cycle where in_valid=1 and in_ready=1; pop SHALL occur where out_valid=1 and out_ready=1.
REQ-019 Storage SHALL be a DEPTH-entry circular buffer with write/read pointers of $clog2(DEPTH) bits, wrapping DEPTH-1 -> 0 with no gap.
REQ-020 Latency: a word pushed into an empty FIFO SHALL appear on out_data with out_valid=1 in the cycle after the push (1-cycle latency, no bypass).
REQ-021 Order SHALL be strictly first-in first-out; no entry dropped or duplicated.
REQ-022 count SHALL update next cycle: +1 on push only, -1 on pop only, unchanged on simultaneous push and pop or neither.
REQ-023 When full, in_ready=0; simultaneous pop SHALL NOT make in_ready=1 in the same cycle (no combinational ready path from out_ready).
REQ-024 When empty, out_valid=0; simultaneous push SHALL NOT produce out_valid=1 in the same cycle.
REQ-025 in_valid=1 while in_ready=0 SHALL set ovf the next cycle and SHALL NOT change storage, pointers or count.
REQ-026 out_ready=1 while out_valid=0 SHALL set udf the next cycle and SHALL NOT change pointers or count.
REQ-027 clr_err=1 SHALL clear ovf/udf next cycle; a set condition in the same cycle SHALL take priority (flag remains 1).
REQ-028 in_ready, out_valid and afull SHALL be derived from registered count only.

Reset
REQ-029 rst=1 at a clock edge SHALL set pointers=0, count=0, ovf=0, udf=0; therefore in_ready=1, out_valid=0, afull=0 (AFULL_LVL>=1) from the next cycle.
REQ-030 rst SHALL override push, pop and clr_err in the same cycle; stored data need not be cleared, and out_data is don't-care while out_valid=0.
REQ-031 Reset asserted mid-stream SHALL discard all entries; the first push after reset SHALL be the first word output.

Verification
REQ-032 WIDTH=8, DEPTH=4: push 0x11,0x22,0x33,0x44 with out_ready=0 -> count=4, in_ready=0, afull=1 (from count 3), out_data=0x11 held.
REQ-033 Full FIFO, in_valid=1 with 0x55, out_ready=0 -> ovf=1 next cycle, count=4; drain yields 0x11,0x22,0x33,0x44 only.
REQ-034 Count=2, push and pop every cycle for 10 cycles -> count stays 2, in_ready=1, output order matches input, pointers wrap twice.
REQ-035 Empty FIFO, out_ready=1 -> udf=1; assert clr_err with out_ready=1 still high -> udf stays 1; drop out_ready, clr_err -> udf=0.
REQ-036 Count=3, assert rst for 1 cycle with in_valid=1 -> count=0, out_valid=0, ovf=udf=0; next push 0xA5 appears on out_data one cycle later.
REQ-037 Repeat REQ-032..036 at WIDTH=32, DEPTH=16, AFULL_LVL=12 -> afull asserts exactly at count 12, in_ready=0 at count 16.

Source files
------------

// File: rtl/ifc_pkg.sv
// Shared interface constants for the bus transfer blocks.
package IfcPkg;
    localparam int WIDTH = 8;
endpackage

// File: rtl/bus_xfer_fifo_if.sv
// Producer/consumer handshake plus status for bus_xfer_fifo.
interface bus_xfer_fifo_if #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
);
    localparam int CW = $clog2(DEPTH) + 1;

    logic             in_valid;
    logic [WIDTH-1:0] in_data;
    logic             in_ready;
    logic             out_valid;
    logic [WIDTH-1:0] out_data;
    logic             out_ready;
    logic [CW-1:0]    count;
    logic             afull;
    logic             ovf;
    logic             udf;
    logic             clr_err;

    modport master (
        output in_valid, in_data, out_ready, clr_err,
        input  in_ready, out_valid, out_data, count, afull, ovf, udf
    );

    modport slave (
        input  in_valid, in_data, out_ready, clr_err,
        output in_ready, out_valid, out_data, count, afull, ovf, udf
    );
endinterface

// File: rtl/bus_xfer_fifo.sv
// Synchronous circular-buffer FIFO with occupancy count, almost-full and
// sticky overflow/underflow flags.
module bus_xfer_fifo
    import IfcPkg::*;
#(
    parameter int WIDTH     = IfcPkg::WIDTH,
    parameter int DEPTH     = 4,
    parameter int AFULL_LVL = DEPTH - 1
) (
    input logic            clk,
    input logic            rst,
    bus_xfer_fifo_if.slave bus
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    if (WIDTH < 1) begin : g_bad_width
        $error("WIDTH must be >= 1");
    end
    if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
        $error("DEPTH must be a power of two >= 2");
    end
    if (AFULL_LVL < 1 || AFULL_LVL > DEPTH) begin : g_bad_afull
        $error("AFULL_LVL must be in 1..DEPTH");
    end

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr_q;
    logic [AW-1:0]    rd_ptr_q;
    logic [CW-1:0]    count_q;
    logic             ovf_q;
    logic             udf_q;
    logic             push;
    logic             pop;

    // Handshake status comes only from the registered count, so out_ready
    // never reaches in_ready combinationally (and in_valid never reaches out_valid).
    always_comb begin
        bus.in_ready  = (count_q != CW'(DEPTH));
        bus.out_valid = (count_q != '0);
        bus.afull     = (count_q >= CW'(AFULL_LVL));
        bus.count     = count_q;
        bus.ovf       = ovf_q;
        bus.udf       = udf_q;
        bus.out_data  = mem[rd_ptr_q];
        push          = bus.in_valid && bus.in_ready;
        pop           = bus.out_valid && bus.out_ready;
    end

    always_ff @(posedge clk) begin
        if (!rst && push) begin
            mem[wr_ptr_q] <= bus.in_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            ovf_q    <= 1'b0;
            udf_q    <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr_q <= wr_ptr_q + AW'(1);
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + AW'(1);
            end
            if (push && !pop) begin
                count_q <= count_q + CW'(1);
            end else if (pop && !push) begin
                count_q <= count_q - CW'(1);
            end
            // A fresh error in the same cycle wins over clr_err.
            if (bus.in_valid && !bus.in_ready) begin
                ovf_q <= 1'b1;
            end else if (bus.clr_err) begin
                ovf_q <= 1'b0;
            end
            if (bus.out_ready && !bus.out_valid) begin
                udf_q <= 1'b1;
            end else if (bus.clr_err) begin
                udf_q <= 1'b0;
            end
        end
    end
endmodule
